// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand request / result bus between source, adder controller and consumer
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output start, op_a, op_b, cin,
        input  busy, done, result, cout
    );

    modport slave (
        input  start, op_a, op_b, cin,
        output busy, done, result, cout
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder driving an external 4-bit adder slice, LSB nibble first
module nibble_serial_adder #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus,
    output logic [3:0]            add_a,
    output logic [3:0]            add_b,
    output logic                  add_cin,
    input  logic [3:0]            add_sum,
    input  logic                  add_cout
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;

    assign bus.busy   = state != IDLE;
    assign bus.done   = state == DONE;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;

    // Present the current nibble pair and the carry to the slice only while running
    always_comb begin
        add_a   = (state == RUN) ? a_q[4*idx +: 4] : 4'h0;
        add_b   = (state == RUN) ? b_q[4*idx +: 4] : 4'h0;
        add_cin = (state == RUN) ? carry : 1'b0;
    end

    // Accept a request, ripple one nibble per clock through the carry register, then pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                state    <= RUN;
                a_q      <= bus.op_a;
                b_q      <= bus.op_b;
                carry    <= bus.cin;
                idx      <= '0;
                result_q <= '0;
            end
        end else if (state == RUN) begin
            result_q[4*idx +: 4] <= add_sum;
            carry                <= add_cout;
            idx                  <= idx + IW'(1);
            if (idx == LAST) begin
                cout_q <= add_cout;
                state  <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized and directed checks of the serial adder (WIDTH=16 and WIDTH=4)
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(16)) b16 ();
    nibble_serial_adder_if #(.WIDTH(4))  b4 ();

    logic [3:0] a16_a, a16_b, a16_s, a4_a, a4_b, a4_s;
    logic       a16_ci, a16_co, a4_ci, a4_co;

    // combinational 4-bit adder slices sitting next to each controller
    assign {a16_co, a16_s} = {1'b0, a16_a} + {1'b0, a16_b} + {4'b0, a16_ci};
    assign {a4_co, a4_s}   = {1'b0, a4_a} + {1'b0, a4_b} + {4'b0, a4_ci};

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16),
        .add_a(a16_a), .add_b(a16_b), .add_cin(a16_ci),
        .add_sum(a16_s), .add_cout(a16_co)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4),
        .add_a(a4_a), .add_b(a4_b), .add_cin(a4_ci),
        .add_sum(a4_s), .add_cout(a4_co)
    );

    // reference: the whole sum in one go, plain arithmetic
    function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {16'b0, c};
    endfunction

    // lat counts clock edges after the accepting edge until done is seen (-1 on timeout);
    // returns one edge after done so the block is back in IDLE, with done_after sampled there
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         output logic [15:0] r, output logic co, output int lat, output logic done_after);
        @(negedge clk);
        b16.op_a = a; b16.op_b = b; b16.cin = c; b16.start = 1'b1;
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        b16.op_a = 16'($urandom); b16.op_b = 16'($urandom); b16.cin = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (b16.done) begin
                lat = i;
                break;
            end
        end
        r = b16.result;
        co = b16.cout;
        @(posedge clk);
        #1;
        done_after = b16.done;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        output logic [3:0] r, output logic co, output int lat);
        @(negedge clk);
        b4.op_a = a; b4.op_b = b; b4.cin = c; b4.start = 1'b1;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        b4.op_a = 4'($urandom); b4.op_b = 4'($urandom); b4.cin = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (b4.done) begin
                lat = i;
                break;
            end
        end
        r = b4.result;
        co = b4.cout;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({b16.busy, b16.done, b16.result, b16.cout} !== 19'd0) begin
            n_err++;
            $display("FAIL reset16: busy/done/result/cout=%b/%b/%h/%b want 0/0/0000/0", b16.busy, b16.done, b16.result, b16.cout);
        end
        n_vec++;
        if ({b4.busy, b4.done, b4.result, b4.cout} !== 7'd0) begin
            n_err++;
            $display("FAIL reset4: busy/done/result/cout=%b/%b/%h/%b want 0/0/0/0", b4.busy, b4.done, b4.result, b4.cout);
        end
        n_vec++;
        if ({a16_a, a16_b, a16_ci} !== 9'd0) begin
            n_err++;
            $display("FAIL idle_slice: add_a/add_b/add_cin=%h/%h/%b want 0/0/0", a16_a, a16_b, a16_ci);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] av[4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h8000};
        logic [15:0] bv[4] = '{16'h4321, 16'h0001, 16'h0000, 16'h8000};
        logic        cv[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] r;
        logic        co, da;
        int          lat;
        logic [16:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = ref16(av[i], bv[i], cv[i]);
            run16(av[i], bv[i], cv[i], r, co, lat, da);
            n_vec++;
            if ({co, r} !== exp) begin
                n_err++;
                $display("FAIL directed%0d: %h+%h+%b got cout/result=%b/%h want %b/%h", i, av[i], bv[i], cv[i], co, r, exp[16], exp[15:0]);
            end
            n_vec++;
            if (lat != 4) begin
                n_err++;
                $display("FAIL directed%0d_latency: done %0d edges after start, want 4", i, lat);
            end
            n_vec++;
            if (da !== 1'b0) begin
                n_err++;
                $display("FAIL directed%0d_pulse: done still %b one cycle later, want 0", i, da);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, r;
        logic        c, co, da;
        int          lat;
        logic [16:0] exp;
        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
            exp = ref16(a, b, c);
            run16(a, b, c, r, co, lat, da);
            n_vec++;
            if ({co, r} !== exp || lat != 4 || da !== 1'b0) begin
                n_err++;
                $display("FAIL random: %h+%h+%b got %b/%h lat %0d done_after %b want %b/%h lat 4 done_after 0", a, b, c, co, r, lat, da, exp[16], exp[15:0]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [16:0] exp;
        int          dones;
        dones = 0;
        exp = ref16(16'h0F0F, 16'h0101, 1'b1);
        @(negedge clk);
        b16.op_a = 16'h0F0F; b16.op_b = 16'h0101; b16.cin = 1'b1; b16.start = 1'b1;
        @(posedge clk);
        #1;
        // after edge e: RUN for e=0..3, DONE after e=4; start is re-raised for edge 2 (RUN) and edge 5 (DONE)
        for (int e = 0; e < 10; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            if (b16.done) dones++;
            b16.start = (e == 1 || e == 4);
            b16.op_a = 16'hAAAA; b16.op_b = 16'h5555; b16.cin = 1'b1;
        end
        b16.start = 1'b0;
        n_vec++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL ignore_done_count: %0d done pulses, want 1", dones);
        end
        n_vec++;
        if ({b16.cout, b16.result} !== exp) begin
            n_err++;
            $display("FAIL ignore_result: cout/result=%b/%h want %b/%h", b16.cout, b16.result, exp[16], exp[15:0]);
        end
        n_vec++;
        if (b16.busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_busy: busy=%b want 0 (no queued add)", b16.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        logic        co, da;
        int          lat;
        @(negedge clk);
        b16.op_a = 16'hFFFF; b16.op_b = 16'h0001; b16.cin = 1'b0; b16.start = 1'b1;
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({b16.busy, b16.done, b16.result, b16.cout} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_mid: busy/done/result/cout=%b/%b/%h/%b want 0/0/0000/0", b16.busy, b16.done, b16.result, b16.cout);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (b16.done !== 1'b0 || b16.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_hold: busy/done=%b/%b want 0/0", b16.busy, b16.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run16(16'h000A, 16'h0006, 1'b0, r, co, lat, da);
        n_vec++;
        if ({co, r} !== 17'h00010 || lat != 4) begin
            n_err++;
            $display("FAIL reset_mid_after: cout/result=%b/%h lat %0d want 0/0010 lat 4", co, r, lat);
        end
    endtask

    task automatic test_exhaustive4();
        logic [3:0] r;
        logic       co;
        int         lat;
        int         s;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    s = a + b + c;
                    run4(4'(a), 4'(b), 1'(c), r, co, lat);
                    n_vec++;
                    if ({co, r} !== 5'(s) || lat != 1) begin
                        n_err++;
                        $display("FAIL exhaustive4: %0d+%0d+%0d got %b/%h lat %0d want %b/%h lat 1", a, b, c, co, r, lat, s[4], s[3:0]);
                    end
                end
    endtask

    initial begin
        b16.start = 1'b0; b16.op_a = '0; b16.op_b = '0; b16.cin = 1'b0;
        b4.start = 1'b0; b4.op_a = '0; b4.op_b = '0; b4.cin = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_exhaustive4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
